seg_scan_display: RTL and testbench

//  Parametrised time-multiplexed 7-segment driver: scans N_DIGITS hex digits onto shared segment lines.

---
 rtl/seg_pkg.sv | 22 ++
 rtl/seg_scan_display_if.sv | 23 ++
 rtl/seg_hex_decoder.sv | 16 +
 rtl/seg_scan_display.sv | 153 +++++++++++++++
 tb/tb_seg_scan_display.sv | 171 +++++++++++++++++
 5 files changed

// File: rtl/seg_pkg.sv
// Shared constants for the 7-segment scan driver: segment bit positions and the hex glyph table.
package seg_pkg;

   localparam int SEG_W  = 8;
   localparam int SEG_A  = 0;
   localparam int SEG_B  = 1;
   localparam int SEG_C  = 2;
   localparam int SEG_D  = 3;
   localparam int SEG_E  = 4;
   localparam int SEG_F  = 5;
   localparam int SEG_G  = 6;
   localparam int SEG_DP = 7;

   typedef logic [SEG_W-1:0] seg_pattern_t;

   // Active-high {g,f,e,d,c,b,a} glyphs for 0..F (lower-case b and d)
   localparam logic [6:0] HEX_SEG [16] = '{
      7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
      7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71
   };

endpackage

// File: rtl/seg_scan_display_if.sv
// Bundle of display data inputs and board-facing scan outputs for seg_scan_display.
interface seg_scan_display_if #(
   parameter int N_DIGITS = 8
);
   logic [4*N_DIGITS-1:0]      digits;
   logic [N_DIGITS-1:0]        en;
   logic [N_DIGITS-1:0]        en_point;
   logic [N_DIGITS-1:0]        blink;
   logic [3:0]                 brightness;
   logic [N_DIGITS-1:0]        seg_en;
   logic [seg_pkg::SEG_W-1:0]  seg_out;
   logic                       frame_start;

   modport master (
      output digits, en, en_point, blink, brightness,
      input  seg_en, seg_out, frame_start
   );

   modport slave (
      input  digits, en, en_point, blink, brightness,
      output seg_en, seg_out, frame_start
   );
endinterface

// File: rtl/seg_hex_decoder.sv
// Combinational hex digit plus decimal point to active-high 8-bit segment pattern.
module seg_hex_decoder
   import seg_pkg::*;
(
   input  logic [3:0]       value_i,
   input  logic             dp_i,
   output logic [SEG_W-1:0] pattern_o
);

   always_comb begin
      pattern_o               = '0;
      pattern_o[SEG_G:SEG_A]  = HEX_SEG[value_i];
      pattern_o[SEG_DP]       = dp_i;
   end

endmodule

// File: rtl/seg_scan_display.sv
// Time-multiplexed 7-segment scanner with blink, 16-level PWM brightness,
// a per-slot blanking gap and a once-per-frame input snapshot.
module seg_scan_display
   import seg_pkg::*;
#(
   parameter int N_DIGITS        = 8,
   parameter int TICKS_PER_DIGIT = 50000,
   parameter int BLANK_TICKS     = 500,
   parameter int BLINK_FRAMES    = 250,
   parameter bit SEG_ACTIVE_LOW  = 1'b1
) (
   input  logic               clk,
   input  logic               rst_n,
   seg_scan_display_if.slave  bus
);

   localparam int TICK_W  = $clog2(TICKS_PER_DIGIT);
   localparam int SLOT_W  = (N_DIGITS > 1) ? $clog2(N_DIGITS) : 1;
   localparam int FRAME_W = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;
   localparam int WINDOW  = TICKS_PER_DIGIT - BLANK_TICKS;
   localparam int PROD_W  = $clog2(WINDOW * 15 + 1);
   localparam logic [SEG_W-1:0] SEG_OFF = SEG_ACTIVE_LOW ? {SEG_W{1'b1}} : {SEG_W{1'b0}};

   logic [TICK_W-1:0]     tick_q, tick_d;
   logic [SLOT_W-1:0]     slot_q, slot_d;
   logic [FRAME_W-1:0]    frameCnt_q, frameCnt_d;
   logic                  blinkPhase_q, blinkPhase_d;
   logic                  frameStart_q, frameStart_d;
   logic                  frameEnd;

   logic [4*N_DIGITS-1:0] digitsSnap_q;
   logic [N_DIGITS-1:0]   enSnap_q;
   logic [N_DIGITS-1:0]   pointSnap_q;
   logic [N_DIGITS-1:0]   blinkSnap_q;
   logic [3:0]            brightSnap_q;

   logic [N_DIGITS-1:0]   segEn_q, segEn_d;
   logic [SEG_W-1:0]      segOut_q, segOut_d;

   logic [3:0]            curDigit;
   logic                  curEn, curPoint, curBlink;
   logic [TICK_W-1:0]     tickOff;
   logic [PROD_W-1:0]     onTime, window;
   logic                  lit;
   seg_pattern_t          pattern;

   // The last tick of the last slot closes a frame: snapshot, frame_start and blink bookkeeping all key off it
   always_comb begin
      frameEnd     = (tick_q == TICK_W'(TICKS_PER_DIGIT - 1)) && (slot_q == SLOT_W'(N_DIGITS - 1));
      tick_d       = tick_q + TICK_W'(1);
      slot_d       = slot_q;
      frameCnt_d   = frameCnt_q;
      blinkPhase_d = blinkPhase_q;
      frameStart_d = frameEnd;
      if (tick_q == TICK_W'(TICKS_PER_DIGIT - 1)) begin
         tick_d = '0;
         slot_d = (slot_q == SLOT_W'(N_DIGITS - 1)) ? '0 : slot_q + SLOT_W'(1);
      end
      if (frameEnd) begin
         if (frameCnt_q == FRAME_W'(BLINK_FRAMES - 1)) begin
            frameCnt_d   = '0;
            blinkPhase_d = ~blinkPhase_q;
         end else begin
            frameCnt_d = frameCnt_q + FRAME_W'(1);
         end
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         tick_q       <= '0;
         slot_q       <= '0;
         frameCnt_q   <= '0;
         blinkPhase_q <= 1'b0;
         frameStart_q <= 1'b0;
      end else begin
         tick_q       <= tick_d;
         slot_q       <= slot_d;
         frameCnt_q   <= frameCnt_d;
         blinkPhase_q <= blinkPhase_d;
         frameStart_q <= frameStart_d;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         digitsSnap_q <= '0;
         enSnap_q     <= '0;
         pointSnap_q  <= '0;
         blinkSnap_q  <= '0;
         brightSnap_q <= '0;
      end else if (frameEnd) begin
         digitsSnap_q <= bus.digits;
         enSnap_q     <= bus.en;
         pointSnap_q  <= bus.en_point;
         blinkSnap_q  <= bus.blink;
         brightSnap_q <= bus.brightness;
      end
   end

   // PWM compares tick offset against the window scaled by brightness/15 without a divider
   always_comb begin
      curDigit = '0;
      curEn    = 1'b0;
      curPoint = 1'b0;
      curBlink = 1'b0;
      for (int i = 0; i < N_DIGITS; i++) begin
         if (slot_q == SLOT_W'(i)) begin
            curDigit = digitsSnap_q[4*i +: 4];
            curEn    = enSnap_q[i];
            curPoint = pointSnap_q[i];
            curBlink = blinkSnap_q[i];
         end
      end
      tickOff = tick_q - TICK_W'(BLANK_TICKS);
      onTime  = PROD_W'(tickOff) * PROD_W'(15);
      window  = PROD_W'(WINDOW) * PROD_W'(brightSnap_q);
      lit     = (tick_q >= TICK_W'(BLANK_TICKS)) && (onTime < window)
                && curEn && !(curBlink && blinkPhase_q);
   end

   seg_hex_decoder u_decoder (
      .value_i   (curDigit),
      .dp_i      (curPoint),
      .pattern_o (pattern)
   );

   always_comb begin
      segEn_d  = '1;
      segOut_d = SEG_OFF;
      if (lit) begin
         for (int i = 0; i < N_DIGITS; i++) begin
            segEn_d[i] = (slot_q != SLOT_W'(i));
         end
         segOut_d = SEG_ACTIVE_LOW ? ~pattern : pattern;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         segEn_q  <= '1;
         segOut_q <= SEG_OFF;
      end else begin
         segEn_q  <= segEn_d;
         segOut_q <= segOut_d;
      end
   end

   assign bus.seg_en      = segEn_q;
   assign bus.seg_out     = segOut_q;
   assign bus.frame_start = frameStart_q;

endmodule

// File: tb/tb_seg_scan_display.sv
// Directed self-checking bench for seg_scan_display with a 4-digit, 8-tick-per-slot configuration.
module tb_seg_scan_display;

   localparam int N  = 4;
   localparam int T  = 8;
   localparam int FP = N * T;

   logic clk = 1'b0;
   logic rst_n;

   always #5 clk = ~clk;

   seg_scan_display_if #(.N_DIGITS(N)) bus ();

   seg_scan_display #(
      .N_DIGITS        (N),
      .TICKS_PER_DIGIT (T),
      .BLANK_TICKS     (2),
      .BLINK_FRAMES    (2),
      .SEG_ACTIVE_LOW  (1'b1)
   ) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus)
   );

   int         compareCount  = 0;
   int         mismatchCount = 0;
   logic [3:0] capEn  [FP];
   logic [7:0] capOut [FP];
   logic       capFs  [FP];
   logic       lit1   [5];

   task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
      compareCount++;
      if (observed !== expected) begin
         mismatchCount++;
         $display("[TB] FAIL %s: got 0x%0h, wanted 0x%0h", tag, observed, expected);
      end
   endtask

   task automatic applyStimulus(input logic [15:0] d, input logic [3:0] e, input logic [3:0] p,
                                input logic [3:0] b, input logic [3:0] br);
      bus.digits     = d;
      bus.en         = e;
      bus.en_point   = p;
      bus.blink      = b;
      bus.brightness = br;
   endtask

   task automatic waitFrameStart();
      bit found = 1'b0;
      for (int i = 0; i < 100 && !found; i++) begin
         @(negedge clk);
         if (bus.frame_start) found = 1'b1;
      end
      if (!found) checkOutput("frame_start timeout", 32'd0, 32'd1);
   endtask

   // Entry on the negedge of a frame's first cycle; index j holds outputs for slot j/T, tick j%T
   task automatic captureFrame(input int changeAt, input logic [15:0] newDigits);
      for (int j = 0; j < FP; j++) begin
         @(negedge clk);
         capEn[j]  = bus.seg_en;
         capOut[j] = bus.seg_out;
         capFs[j]  = bus.frame_start;
         if (j == changeAt) bus.digits = newDigits;
      end
   endtask

   task automatic checkSlot(input string tag, input int slot, input logic [3:0] litEn,
                            input logic [7:0] litOut, input int first, input int last);
      for (int t = 0; t < T; t++) begin
         int j = slot * T + t;
         logic [11:0] exp12 = (t >= first && t <= last) ? {litEn, litOut} : 12'hFFF;
         checkOutput($sformatf("%s s%0d t%0d", tag, slot, t), 32'({capEn[j], capOut[j]}), 32'(exp12));
      end
   endtask

   task automatic checkPeriod(input string tag);
      int n = 0;
      for (int j = 0; j < FP - 1; j++) n += int'(capFs[j]);
      checkOutput({tag, " fs mid"}, 32'(n), 32'd0);
      checkOutput({tag, " fs end"}, 32'(capFs[FP-1]), 32'd1);
   endtask

   task automatic check1234(input string tag, input int first, input int last);
      checkSlot(tag, 0, 4'hE, 8'h99, first, last);
      checkSlot(tag, 1, 4'hD, 8'hB0, first, last);
      checkSlot(tag, 2, 4'hB, 8'hA4, first, last);
      checkSlot(tag, 3, 4'h7, 8'hF9, first, last);
   endtask

   initial begin
      rst_n = 1'b0;
      applyStimulus(16'h1234, 4'hF, 4'h0, 4'h0, 4'd15);
      repeat (3) @(negedge clk);
      checkOutput("reset seg_en", 32'(bus.seg_en), 32'h0F);
      checkOutput("reset seg_out", 32'(bus.seg_out), 32'hFF);
      checkOutput("reset frame_start", 32'(bus.frame_start), 32'd0);
      rst_n = 1'b1;

      captureFrame(-1, 16'h0);
      check1234("blank", 1, 0);
      checkPeriod("reset");

      captureFrame(-1, 16'h0);
      check1234("scan", 2, 7);
      checkPeriod("scan");

      applyStimulus(16'h1234, 4'hF, 4'h0, 4'h0, 4'd5);
      waitFrameStart();
      captureFrame(-1, 16'h0);
      check1234("pwm5", 2, 3);

      applyStimulus(16'h1234, 4'hF, 4'h0, 4'h0, 4'd0);
      waitFrameStart();
      captureFrame(-1, 16'h0);
      check1234("pwm0", 1, 0);

      applyStimulus(16'h1234, 4'hF, 4'h1, 4'h2, 4'd15);
      waitFrameStart();
      for (int k = 0; k < 5; k++) begin
         captureFrame(-1, 16'h0);
         lit1[k] = (capEn[T + 2] == 4'hD);
         checkSlot($sformatf("blink f%0d", k), 0, 4'hE, 8'h19, 2, 7);
         checkSlot($sformatf("blink f%0d", k), 1, 4'hD, 8'hB0, 2, lit1[k] ? 7 : 1);
         checkSlot($sformatf("blink f%0d", k), 2, 4'hB, 8'hA4, 2, 7);
         checkSlot($sformatf("blink f%0d", k), 3, 4'h7, 8'hF9, 2, 7);
      end
      for (int k = 0; k < 3; k++) begin
         checkOutput($sformatf("blink cadence f%0d", k), 32'(lit1[k] ^ lit1[k+2]), 32'd1);
      end

      applyStimulus(16'h1234, 4'hF, 4'h0, 4'h0, 4'd15);
      waitFrameStart();
      captureFrame(T + 2, 16'h00AF);
      check1234("snap old", 2, 7);
      captureFrame(-1, 16'h0);
      checkSlot("snap new", 0, 4'hE, 8'h8E, 2, 7);
      checkSlot("snap new", 1, 4'hD, 8'h88, 2, 7);
      checkSlot("snap new", 2, 4'hB, 8'hC0, 2, 7);
      checkSlot("snap new", 3, 4'h7, 8'hC0, 2, 7);

      applyStimulus(16'h1234, 4'h5, 4'h0, 4'h0, 4'd15);
      waitFrameStart();
      captureFrame(-1, 16'h0);
      checkSlot("disabled", 0, 4'hE, 8'h99, 2, 7);
      checkSlot("disabled", 1, 4'hD, 8'hB0, 1, 0);
      checkSlot("disabled", 2, 4'hB, 8'hA4, 2, 7);
      checkSlot("disabled", 3, 4'h7, 8'hF9, 1, 0);
      checkPeriod("disabled");

      applyStimulus(16'h1234, 4'hF, 4'h0, 4'h0, 4'd15);
      waitFrameStart();
      waitFrameStart();
      repeat (5) @(negedge clk);
      checkOutput("pre-reset seg_en", 32'(bus.seg_en), 32'h0E);
      #2 rst_n = 1'b0;
      #1;
      checkOutput("async reset seg_en", 32'(bus.seg_en), 32'h0F);
      checkOutput("async reset seg_out", 32'(bus.seg_out), 32'hFF);
      checkOutput("async reset frame_start", 32'(bus.frame_start), 32'd0);
      @(negedge clk);
      rst_n = 1'b1;

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", compareCount, mismatchCount);
      $finish;
   end

endmodule
